// File: rtl/mc_main_ctrl_pkg.sv
// Types and constants shared by the multicycle MIPS main controller.
// MC_ILLEGAL_TRAP_EN adds the Halt state for unrecognised instructions.
package mc_main_ctrl_pkg;

`ifdef MC_ILLEGAL_TRAP_EN
  localparam int STATE_W = 5;
`else
  localparam int STATE_W = 4;
`endif

  typedef enum logic [STATE_W-1:0] {
    Fetch, Decode, MemAddr, MemRd, MemWrbck, MemWr, RRExec, RRWrbck,
    Branch, Jmp, RIExec, RIWrbck, Lui, Jal, Jalr, Jr
`ifdef MC_ILLEGAL_TRAP_EN
    , Halt
`endif
  } state_type;

  typedef enum logic       {AddrPC, AddrALUout} mem_addr_sel_t;
  typedef enum logic [1:0] {PCPlus4, PCBranch, PCJmp, PCRs} nxt_pc_sel_t;
  typedef enum logic       {SrcaPC, SrcaRs} alu_srca_sel_t;
  typedef enum logic [2:0] {SrcbRt, Four, BeqImm, SrcbImm, Zero} alu_srcb_sel_t;
  typedef enum logic [1:0] {WrRt, WrRd, WrRa} wreg_dst_sel_t;
  typedef enum logic [1:0] {ALUout, MemData, LuiResult, PCPlus4_j} wreg_data_sel_t;
  typedef enum logic [2:0] {BrEq, BrNe, BrGez, BrLtz, BrLez, BrGtz} br_cond_t;

  typedef enum logic [3:0] {
    ALUop_ADD, ALUop_ADDU, ALUop_SUB, ALUop_AND, ALUop_OR,
    ALUop_XOR, ALUop_SLT, ALUop_SLTU, ALUop_RR
  } ALUop_t;

  // Per-state control word; fetch_rdy and pc_br are gated late by mem_rdy / taken.
  typedef struct packed {
    logic           mem_req;
    logic           mem_we;
    logic           fetch_rdy;
    logic           pc_br;
    logic           pc_we;
    logic           reg_we;
    mem_addr_sel_t  addr;
    nxt_pc_sel_t    pc_sel;
    alu_srca_sel_t  srca;
    alu_srcb_sel_t  srcb;
    ALUop_t         alu_op;
    wreg_dst_sel_t  wdst;
    wreg_data_sel_t wdata;
  } ctl_t;

  localparam logic [5:0] OP_RR     = 6'h00;
  localparam logic [5:0] OP_BGELTZ = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

`ifdef MC_ILLEGAL_TRAP_EN
  localparam state_type ILLEGAL_NXT = Halt;
`else
  localparam state_type ILLEGAL_NXT = Fetch;
`endif

  // Functs the ALU's RR decode understands.
  function automatic logic is_rr_alu_funct(input logic [5:0] f);
    case (f)
      F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
      F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
      F_SLT, F_SLTU: return 1'b1;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_main_ctrl_alu_dec.sv
// Combinational decode of opcode to the RIExec ALU op and of opcode/rt
// to the branch condition used in the Branch state.
module mc_alu_dec
  import mc_main_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [4:0] rt,
  output ALUop_t     ri_alu_op,
  output br_cond_t   br_cond
);

  always_comb begin
    ri_alu_op = ALUop_ADD;
    case (opcode)
      OP_ADDI:  ri_alu_op = ALUop_ADD;
      OP_ADDIU: ri_alu_op = ALUop_ADDU;
      OP_ANDI:  ri_alu_op = ALUop_AND;
      OP_ORI:   ri_alu_op = ALUop_OR;
      OP_XORI:  ri_alu_op = ALUop_XOR;
      OP_SLTI:  ri_alu_op = ALUop_SLT;
      OP_SLTIU: ri_alu_op = ALUop_SLTU;
      default:  ri_alu_op = ALUop_ADD;
    endcase
  end

  always_comb begin
    br_cond = BrEq;
    case (opcode)
      OP_BEQ:    br_cond = BrEq;
      OP_BNE:    br_cond = BrNe;
      OP_BGELTZ: br_cond = (rt == 5'd1) ? BrGez : BrLtz;
      OP_BLEZ:   br_cond = BrLez;
      OP_BGTZ:   br_cond = BrGtz;
      default:   br_cond = BrEq;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multicycle MIPS datapath.
// MC_ILLEGAL_TRAP_EN: unrecognised instructions trap into Halt and set illegal_instr.
//
// state    | meaning
// Fetch    | read instr at PC, PC+=4      Decode  | branch target -> ALUout
// MemAddr  | rs+imm -> ALUout             MemRd   | load read
// MemWrbck | load data -> rt              MemWr   | store write
// RRExec   | rs op rt                     RRWrbck | ALUout -> rd
// Branch   | rs-rt / rs-0, cond PC load   Jmp     | PC <- jump target
// RIExec   | rs op imm                    RIWrbck | ALUout -> rt
// Lui      | lui result -> rt             Jal     | ra <- PC+4, PC <- target
// Jalr     | rd <- PC+4, PC <- rs         Jr      | PC <- rs
// Halt     | trapped until reset (trap build only)
module mc_main_ctrl
  import mc_main_ctrl_pkg::*;
#(
  parameter bit MEM_HS = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [5:0]     opcode,
  input  logic [5:0]     funct,
  input  logic [4:0]     rt,
  input  logic           alu_zero,
  input  logic           alu_sign,
  input  logic           mem_rdy,
  output logic           mem_req,
  output logic           mem_we,
  output mem_addr_sel_t  mem_addr_sel,
  output logic           ir_we,
  output logic           pc_we,
  output nxt_pc_sel_t    nxt_pc_sel,
  output alu_srca_sel_t  alu_srca_sel,
  output alu_srcb_sel_t  alu_srcb_sel,
  output ALUop_t         alu_op,
  output logic           reg_we,
  output wreg_dst_sel_t  wreg_dst_sel,
  output wreg_data_sel_t wreg_data_sel,
  output state_type      state_o,
  output logic           illegal_instr
);

  state_type state, nxt;
  ctl_t      ctl;
  ALUop_t    ri_alu_op;
  br_cond_t  br_cond;
  logic      rdy, taken;

  assign rdy = MEM_HS ? mem_rdy : 1'b1;

  mc_alu_dec u_alu_dec (
    .opcode    (opcode),
    .rt        (rt),
    .ri_alu_op (ri_alu_op),
    .br_cond   (br_cond)
  );

  always_comb begin
    case (br_cond)
      BrEq:    taken = alu_zero;
      BrNe:    taken = !alu_zero;
      BrGez:   taken = !alu_sign;
      BrLtz:   taken = alu_sign;
      BrLez:   taken = alu_zero | alu_sign;
      BrGtz:   taken = !alu_zero & !alu_sign;
      default: taken = 1'b0;
    endcase
  end

  function automatic ctl_t decode_ctl(input state_type s, input logic [5:0] op,
                                      input ALUop_t ri_op);
    ctl_t c;
    c        = '0;
    c.addr   = AddrPC;
    c.pc_sel = PCPlus4;
    c.srca   = SrcaPC;
    c.srcb   = SrcbRt;
    c.alu_op = ALUop_ADD;
    c.wdst   = WrRt;
    c.wdata  = ALUout;
    case (s)
      Fetch:    begin c.mem_req = 1'b1; c.fetch_rdy = 1'b1; c.srcb = Four; end
      Decode:   c.srcb = BeqImm;
      MemAddr:  begin c.srca = SrcaRs; c.srcb = SrcbImm; end
      MemRd:    begin c.mem_req = 1'b1; c.addr = AddrALUout; end
      MemWrbck: begin c.reg_we = 1'b1; c.wdata = MemData; end
      MemWr:    begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.addr = AddrALUout; end
      RRExec:   begin c.srca = SrcaRs; c.alu_op = ALUop_RR; end
      RRWrbck:  begin c.reg_we = 1'b1; c.wdst = WrRd; end
      Branch: begin
        c.srca   = SrcaRs;
        c.alu_op = ALUop_SUB;
        c.srcb   = (op == OP_BEQ || op == OP_BNE) ? SrcbRt : Zero;
        c.pc_br  = 1'b1;
        c.pc_sel = PCBranch;
      end
      Jmp:      begin c.pc_we = 1'b1; c.pc_sel = PCJmp; end
      RIExec:   begin c.srca = SrcaRs; c.srcb = SrcbImm; c.alu_op = ri_op; end
      RIWrbck:  c.reg_we = 1'b1;
      Lui:      begin c.reg_we = 1'b1; c.wdata = LuiResult; end
      Jal: begin
        c.reg_we = 1'b1; c.wdst = WrRa; c.wdata = PCPlus4_j;
        c.pc_we  = 1'b1; c.pc_sel = PCJmp;
      end
      Jalr: begin
        c.reg_we = 1'b1; c.wdst = WrRd; c.wdata = PCPlus4_j;
        c.pc_we  = 1'b1; c.pc_sel = PCRs;
      end
      Jr:       begin c.pc_we = 1'b1; c.pc_sel = PCRs; end
      default:  ;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = Fetch;
    case (state)
      Fetch:  nxt = rdy ? Decode : Fetch;
      Decode: begin
        case (opcode)
          OP_LW, OP_SW: nxt = MemAddr;
          OP_RR: begin
            if (funct == F_JR)        nxt = Jr;
            else if (funct == F_JALR) nxt = Jalr;
`ifdef MC_ILLEGAL_TRAP_EN
            else if (!is_rr_alu_funct(funct)) nxt = Halt;
`endif
            else                      nxt = RRExec;
          end
          OP_BEQ, OP_BNE, OP_BGELTZ, OP_BLEZ, OP_BGTZ: nxt = Branch;
          OP_J:   nxt = Jmp;
          OP_JAL: nxt = Jal;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU: nxt = RIExec;
          OP_LUI: nxt = Lui;
          default: nxt = ILLEGAL_NXT;
        endcase
      end
      MemAddr:  nxt = (opcode == OP_LW) ? MemRd : MemWr;
      MemRd:    nxt = rdy ? MemWrbck : MemRd;
      MemWr:    nxt = rdy ? Fetch : MemWr;
      RRExec:   nxt = RRWrbck;
      RIExec:   nxt = RIWrbck;
`ifdef MC_ILLEGAL_TRAP_EN
      Halt:     nxt = Halt;
`endif
      default:  nxt = Fetch;
    endcase
  end

  // Control word is registered alongside the state so both always agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= Fetch;
      ctl   <= decode_ctl(Fetch, OP_RR, ALUop_ADD);
    end else begin
      state <= nxt;
      ctl   <= decode_ctl(nxt, opcode, ri_alu_op);
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               illegal_q <= 1'b0;
    else if (state == Decode && nxt == Halt)  illegal_q <= 1'b1;
  end
  assign illegal_instr = illegal_q;
`else
  assign illegal_instr = 1'b0;
`endif

  // rst_n gating keeps every enable low while reset is held.
  assign mem_req       = rst_n & ctl.mem_req;
  assign mem_we        = rst_n & ctl.mem_we;
  assign ir_we         = rst_n & ctl.fetch_rdy & rdy;
  assign pc_we         = rst_n & (ctl.pc_we | (ctl.fetch_rdy & rdy) | (ctl.pc_br & taken));
  assign reg_we        = rst_n & ctl.reg_we;
  assign mem_addr_sel  = ctl.addr;
  assign nxt_pc_sel    = ctl.pc_sel;
  assign alu_srca_sel  = ctl.srca;
  assign alu_srcb_sel  = ctl.srcb;
  assign alu_op        = ctl.alu_op;
  assign wreg_dst_sel  = ctl.wdst;
  assign wreg_data_sel = ctl.wdata;
  assign state_o       = state;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed bench for mc_main_ctrl: per-cycle vector table plus reset and
// illegal-instruction sequences.
module tb_mc_main_ctrl;
  import mc_main_ctrl_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [5:0]     opcode = 6'h0, funct = 6'h0;
  logic [4:0]     rt = 5'h0;
  logic           alu_zero = 1'b0, alu_sign = 1'b0, mem_rdy = 1'b0;
  logic           mem_req, mem_we, ir_we, pc_we, reg_we, illegal_instr;
  mem_addr_sel_t  mem_addr_sel;
  nxt_pc_sel_t    nxt_pc_sel;
  alu_srca_sel_t  alu_srca_sel;
  alu_srcb_sel_t  alu_srcb_sel;
  ALUop_t         alu_op;
  wreg_dst_sel_t  wreg_dst_sel;
  wreg_data_sel_t wreg_data_sel;
  state_type      state_o;

  always #5 clk = ~clk;

  mc_main_ctrl #(.MEM_HS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .rt(rt),
    .alu_zero(alu_zero), .alu_sign(alu_sign), .mem_rdy(mem_rdy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .nxt_pc_sel(nxt_pc_sel),
    .alu_srca_sel(alu_srca_sel), .alu_srcb_sel(alu_srcb_sel), .alu_op(alu_op),
    .reg_we(reg_we), .wreg_dst_sel(wreg_dst_sel), .wreg_data_sel(wreg_data_sel),
    .state_o(state_o), .illegal_instr(illegal_instr)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [5:0]     op;
    logic [5:0]     fn;
    logic [4:0]     rt;
    logic [2:0]     zsr;   // {alu_zero, alu_sign, mem_rdy}
    state_type      st;
    logic [4:0]     en;    // {mem_req, mem_we, ir_we, pc_we, reg_we}
    mem_addr_sel_t  as;
    nxt_pc_sel_t    ps;
    alu_srca_sel_t  sa;
    alu_srcb_sel_t  sb;
    ALUop_t         ao;
    wreg_dst_sel_t  wd;
    wreg_data_sel_t wdat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_sel(mem_addr_sel_t a, nxt_pc_sel_t p, alu_srca_sel_t sa,
                                           alu_srcb_sel_t sb, ALUop_t ao, wreg_dst_sel_t wd,
                                           wreg_data_sel_t wdat);
    return 32'({a, p, sa, sb, ao, wd, wdat});
  endfunction

  function automatic logic [31:0] got_en();
    return 32'({mem_req, mem_we, ir_we, pc_we, reg_we});
  endfunction

  function automatic vec_t mk(logic [5:0] op, logic [5:0] fn, logic [4:0] r, logic [2:0] zsr,
                              state_type st, logic [4:0] en, mem_addr_sel_t as, nxt_pc_sel_t ps,
                              alu_srca_sel_t sa, alu_srcb_sel_t sb, ALUop_t ao,
                              wreg_dst_sel_t wd, wreg_data_sel_t wdat);
    vec_t v;
    v.op = op; v.fn = fn; v.rt = r; v.zsr = zsr; v.st = st; v.en = en;
    v.as = as; v.ps = ps; v.sa = sa; v.sb = sb; v.ao = ao; v.wd = wd; v.wdat = wdat;
    return v;
  endfunction

  function automatic vec_t fetch_row(logic [5:0] op, logic [5:0] fn, logic [4:0] r, logic rdy);
    return mk(op, fn, r, {2'b00, rdy}, Fetch, rdy ? 5'b10110 : 5'b10000,
              AddrPC, PCPlus4, SrcaPC, Four, ALUop_ADD, WrRt, ALUout);
  endfunction

  function automatic vec_t dec_row(logic [5:0] op, logic [5:0] fn, logic [4:0] r);
    return mk(op, fn, r, 3'b001, Decode, 5'b00000,
              AddrPC, PCPlus4, SrcaPC, BeqImm, ALUop_ADD, WrRt, ALUout);
  endfunction

  task automatic build_table();
    // J
    vecs.push_back(fetch_row(OP_J, 6'h00, 5'd0, 1'b1));
    vecs.push_back(dec_row(OP_J, 6'h00, 5'd0));
    vecs.push_back(mk(OP_J, 6'h00, 5'd0, 3'b001, Jmp, 5'b00010, AddrPC, PCJmp, SrcaPC, SrcbRt, ALUop_ADD, WrRt, ALUout));
    // LW with 2 Fetch and 3 MemRd wait cycles
    vecs.push_back(fetch_row(OP_LW, 6'h00, 5'd0, 1'b0));
    vecs.push_back(fetch_row(OP_LW, 6'h00, 5'd0, 1'b0));
    vecs.push_back(fetch_row(OP_LW, 6'h00, 5'd0, 1'b1));
    vecs.push_back(dec_row(OP_LW, 6'h00, 5'd0));
    vecs.push_back(mk(OP_LW, 6'h00, 5'd0, 3'b001, MemAddr, 5'b00000, AddrPC, PCPlus4, SrcaRs, SrcbImm, ALUop_ADD, WrRt, ALUout));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(OP_LW, 6'h00, 5'd0, 3'b000, MemRd, 5'b10000, AddrALUout, PCPlus4, SrcaPC, SrcbRt, ALUop_ADD, WrRt, ALUout));
    vecs.push_back(mk(OP_LW, 6'h00, 5'd0, 3'b001, MemRd, 5'b10000, AddrALUout, PCPlus4, SrcaPC, SrcbRt, ALUop_ADD, WrRt, ALUout));
    vecs.push_back(mk(OP_LW, 6'h00, 5'd0, 3'b001, MemWrbck, 5'b00001, AddrPC, PCPlus4, SrcaPC, SrcbRt, ALUop_ADD, WrRt, MemData));
    // BEQ taken / not taken
    vecs.push_back(fetch_row(OP_BEQ, 6'h00, 5'd0, 1'b1));
    vecs.push_back(dec_row(OP_BEQ, 6'h00, 5'd0));
    vecs.push_back(mk(OP_BEQ, 6'h00, 5'd0, 3'b101, Branch, 5'b00010, AddrPC, PCBranch, SrcaRs, SrcbRt, ALUop_SUB, WrRt, ALUout));
    vecs.push_back(fetch_row(OP_BEQ, 6'h00, 5'd0, 1'b1));
    vecs.push_back(dec_row(OP_BEQ, 6'h00, 5'd0));
    vecs.push_back(mk(OP_BEQ, 6'h00, 5'd0, 3'b001, Branch, 5'b00000, AddrPC, PCBranch, SrcaRs, SrcbRt, ALUop_SUB, WrRt, ALUout));
    // BGELTZ: rt=0 (BLTZ) sign=1 taken, rt=1 (BGEZ) sign=1 not taken
    vecs.push_back(fetch_row(OP_BGELTZ, 6'h00, 5'd0, 1'b1));
    vecs.push_back(dec_row(OP_BGELTZ, 6'h00, 5'd0));
    vecs.push_back(mk(OP_BGELTZ, 6'h00, 5'd0, 3'b011, Branch, 5'b00010, AddrPC, PCBranch, SrcaRs, Zero, ALUop_SUB, WrRt, ALUout));
    vecs.push_back(fetch_row(OP_BGELTZ, 6'h00, 5'd1, 1'b1));
    vecs.push_back(dec_row(OP_BGELTZ, 6'h00, 5'd1));
    vecs.push_back(mk(OP_BGELTZ, 6'h00, 5'd1, 3'b011, Branch, 5'b00000, AddrPC, PCBranch, SrcaRs, Zero, ALUop_SUB, WrRt, ALUout));
    // ADDIU, SLTIU
    vecs.push_back(fetch_row(OP_ADDIU, 6'h00, 5'd0, 1'b1));
    vecs.push_back(dec_row(OP_ADDIU, 6'h00, 5'd0));
    vecs.push_back(mk(OP_ADDIU, 6'h00, 5'd0, 3'b001, RIExec, 5'b00000, AddrPC, PCPlus4, SrcaRs, SrcbImm, ALUop_ADDU, WrRt, ALUout));
    vecs.push_back(mk(OP_ADDIU, 6'h00, 5'd0, 3'b001, RIWrbck, 5'b00001, AddrPC, PCPlus4, SrcaPC, SrcbRt, ALUop_ADD, WrRt, ALUout));
    vecs.push_back(fetch_row(OP_SLTIU, 6'h00, 5'd0, 1'b1));
    vecs.push_back(dec_row(OP_SLTIU, 6'h00, 5'd0));
    vecs.push_back(mk(OP_SLTIU, 6'h00, 5'd0, 3'b001, RIExec, 5'b00000, AddrPC, PCPlus4, SrcaRs, SrcbImm, ALUop_SLTU, WrRt, ALUout));
    vecs.push_back(mk(OP_SLTIU, 6'h00, 5'd0, 3'b001, RIWrbck, 5'b00001, AddrPC, PCPlus4, SrcaPC, SrcbRt, ALUop_ADD, WrRt, ALUout));
    // JALR, JR
    vecs.push_back(fetch_row(OP_RR, 6'h09, 5'd0, 1'b1));
    vecs.push_back(dec_row(OP_RR, 6'h09, 5'd0));
    vecs.push_back(mk(OP_RR, 6'h09, 5'd0, 3'b001, Jalr, 5'b00011, AddrPC, PCRs, SrcaPC, SrcbRt, ALUop_ADD, WrRd, PCPlus4_j));
    vecs.push_back(fetch_row(OP_RR, 6'h08, 5'd0, 1'b1));
    vecs.push_back(dec_row(OP_RR, 6'h08, 5'd0));
    vecs.push_back(mk(OP_RR, 6'h08, 5'd0, 3'b001, Jr, 5'b00010, AddrPC, PCRs, SrcaPC, SrcbRt, ALUop_ADD, WrRt, ALUout));
    // RR ADD
    vecs.push_back(fetch_row(OP_RR, 6'h20, 5'd0, 1'b1));
    vecs.push_back(dec_row(OP_RR, 6'h20, 5'd0));
    vecs.push_back(mk(OP_RR, 6'h20, 5'd0, 3'b001, RRExec, 5'b00000, AddrPC, PCPlus4, SrcaRs, SrcbRt, ALUop_RR, WrRt, ALUout));
    vecs.push_back(mk(OP_RR, 6'h20, 5'd0, 3'b001, RRWrbck, 5'b00001, AddrPC, PCPlus4, SrcaPC, SrcbRt, ALUop_ADD, WrRd, ALUout));
    // SW with one MemWr wait cycle
    vecs.push_back(fetch_row(OP_SW, 6'h00, 5'd0, 1'b1));
    vecs.push_back(dec_row(OP_SW, 6'h00, 5'd0));
    vecs.push_back(mk(OP_SW, 6'h00, 5'd0, 3'b001, MemAddr, 5'b00000, AddrPC, PCPlus4, SrcaRs, SrcbImm, ALUop_ADD, WrRt, ALUout));
    vecs.push_back(mk(OP_SW, 6'h00, 5'd0, 3'b000, MemWr, 5'b11000, AddrALUout, PCPlus4, SrcaPC, SrcbRt, ALUop_ADD, WrRt, ALUout));
    vecs.push_back(mk(OP_SW, 6'h00, 5'd0, 3'b001, MemWr, 5'b11000, AddrALUout, PCPlus4, SrcaPC, SrcbRt, ALUop_ADD, WrRt, ALUout));
    // LUI, JAL
    vecs.push_back(fetch_row(OP_LUI, 6'h00, 5'd0, 1'b1));
    vecs.push_back(dec_row(OP_LUI, 6'h00, 5'd0));
    vecs.push_back(mk(OP_LUI, 6'h00, 5'd0, 3'b001, Lui, 5'b00001, AddrPC, PCPlus4, SrcaPC, SrcbRt, ALUop_ADD, WrRt, LuiResult));
    vecs.push_back(fetch_row(OP_JAL, 6'h00, 5'd0, 1'b1));
    vecs.push_back(dec_row(OP_JAL, 6'h00, 5'd0));
    vecs.push_back(mk(OP_JAL, 6'h00, 5'd0, 3'b001, Jal, 5'b00011, AddrPC, PCJmp, SrcaPC, SrcbRt, ALUop_ADD, WrRa, PCPlus4_j));
    // BNE zero=0 taken, BLEZ z=0 s=0 not taken, BGTZ z=0 s=0 taken
    vecs.push_back(fetch_row(OP_BNE, 6'h00, 5'd0, 1'b1));
    vecs.push_back(dec_row(OP_BNE, 6'h00, 5'd0));
    vecs.push_back(mk(OP_BNE, 6'h00, 5'd0, 3'b001, Branch, 5'b00010, AddrPC, PCBranch, SrcaRs, SrcbRt, ALUop_SUB, WrRt, ALUout));
    vecs.push_back(fetch_row(OP_BLEZ, 6'h00, 5'd0, 1'b1));
    vecs.push_back(dec_row(OP_BLEZ, 6'h00, 5'd0));
    vecs.push_back(mk(OP_BLEZ, 6'h00, 5'd0, 3'b001, Branch, 5'b00000, AddrPC, PCBranch, SrcaRs, Zero, ALUop_SUB, WrRt, ALUout));
    vecs.push_back(fetch_row(OP_BGTZ, 6'h00, 5'd0, 1'b1));
    vecs.push_back(dec_row(OP_BGTZ, 6'h00, 5'd0));
    vecs.push_back(mk(OP_BGTZ, 6'h00, 5'd0, 3'b001, Branch, 5'b00010, AddrPC, PCBranch, SrcaRs, Zero, ALUop_SUB, WrRt, ALUout));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got stuck expected done");
    $fatal(1);
  end

  initial begin
    build_table();
    opcode = OP_J; mem_rdy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset state", 32'(state_o), 32'(Fetch));
    check("reset enables", got_en(), 32'h0);
    check("reset illegal", 32'(illegal_instr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      opcode = vecs[i].op; funct = vecs[i].fn; rt = vecs[i].rt;
      {alu_zero, alu_sign, mem_rdy} = vecs[i].zsr;
      #1;
      check($sformatf("v%0d state", i), 32'(state_o), 32'(vecs[i].st));
      check($sformatf("v%0d enables", i), got_en(), 32'(vecs[i].en));
      check($sformatf("v%0d selects", i),
            pack_sel(mem_addr_sel, nxt_pc_sel, alu_srca_sel, alu_srcb_sel, alu_op, wreg_dst_sel, wreg_data_sel),
            pack_sel(vecs[i].as, vecs[i].ps, vecs[i].sa, vecs[i].sb, vecs[i].ao, vecs[i].wd, vecs[i].wdat));
      @(negedge clk);
    end

    // Reset dropped in the middle of MemRd
    opcode = OP_LW; funct = 6'h00; rt = 5'd0; alu_zero = 1'b0; alu_sign = 1'b0; mem_rdy = 1'b1;
    #1; check("pre-lw state", 32'(state_o), 32'(Fetch));
    @(negedge clk);
    @(negedge clk);
    mem_rdy = 1'b0;
    @(negedge clk);
    #1;
    check("midrd state", 32'(state_o), 32'(MemRd));
    check("midrd enables", got_en(), 32'h10);
    mem_rdy = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async rst state", 32'(state_o), 32'(Fetch));
    check("async rst enables", got_en(), 32'h0);
    @(negedge clk);
    #1;
    check("held rst state", 32'(state_o), 32'(Fetch));
    check("held rst enables", got_en(), 32'h0);
    rst_n = 1'b1;
    opcode = 6'h3F;
    #1;
    check("release enables", got_en(), 32'h16);
    @(negedge clk);
    #1;
    check("illegal decode state", 32'(state_o), 32'(Decode));
    @(negedge clk);
    #1;
`ifdef MC_ILLEGAL_TRAP_EN
    for (int c = 0; c < 10; c++) begin
      check($sformatf("halt%0d state", c), 32'(state_o), 32'(Halt));
      check($sformatf("halt%0d enables", c), got_en(), 32'h0);
      check($sformatf("halt%0d illegal", c), 32'(illegal_instr), 32'h1);
      @(negedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("halt reset state", 32'(state_o), 32'(Fetch));
    check("halt reset illegal", 32'(illegal_instr), 32'h0);
    rst_n = 1'b1;
`else
    check("nop opcode state", 32'(state_o), 32'(Fetch));
    check("nop opcode enables", got_en(), 32'h16);
    check("nop illegal tied", 32'(illegal_instr), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. Decodes the latched instruction fields (opcode, funct, rt) and walks the 16-state multicycle sequence. Drives every datapath select, write enable and ALU operation. Handshakes with the unified instruction/data memory, and sits directly upstream of the datapath muxes, IR/PC registers and ALU.

Parameters:
MEM_HS, 1, 1 = Fetch/MemRd/MemWr wait for mem_rdy; 0 = memory assumed single-cycle and mem_rdy is ignored (treated as 1).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], stable from the Decode cycle until the next Fetch completes
funct  in  6  IR[5:0]
rt  in  5  IR[20:16], selects BGEZ (1) or BLTZ (0) under the BGELTZ opcode
alu_zero  in  1  ALU result == 0, current cycle
alu_sign  in  1  ALU result[31], current cycle
mem_rdy  in  1  memory completes the current request this cycle
mem_req  out  1  memory access request
mem_we  out  1  memory write
mem_addr_sel  out  mem_addr_sel_t  AddrPC / AddrALUout
ir_we  out  1  load the instruction register
pc_we  out  1  load the PC
nxt_pc_sel  out  nxt_pc_sel  PC source
alu_srca_sel  out  alu_srca_sel_t
alu_srcb_sel  out  alu_srcb_sel_t
alu_op  out  ALUop_t
reg_we  out  1  register file write
wreg_dst_sel  out  wreg_dst_sel_t
wreg_data_sel  out  wreg_data_sel_t
state_o  out  state_type  current state, for debug and trace
illegal_instr  out  1  sticky flag (optional feature only; tied 0 otherwise)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- While rst_n is low: state = Fetch; mem_req, mem_we, ir_we, pc_we and reg_we are forced to 0. A reset in mid-instruction abandons it, and the memory side must tolerate a dropped request.
- Outputs are Moore, decoded from the state. The only exceptions are gating by mem_rdy (Fetch/MemRd/MemWr) and by the branch condition (Branch).
- Selects not listed for a state default to: AddrPC, SrcaPC, SrcbRt, ALUop_ADD, WrRt, ALUout, PCPlus4. Every enable not listed is 0.
- Fetch:
  - Outputs: mem_req=1, AddrPC, SrcaPC, Four, ADD, nxt PCPlus4.
  - ir_we = pc_we = mem_rdy.
  - Goes to Decode on mem_rdy; otherwise holds.
- Decode:
  - Outputs: SrcaPC, BeqImm, ADD. The branch target (PC+4 + sext(imm)<<2) is latched into ALUout by the datapath.
  - Next state by opcode:
    - LW, SW -> MemAddr
    - RR with funct JR -> Jr; with funct JALR -> Jalr; any other funct -> RRExec
    - BEQ, BNE, BGELTZ, BLEZ, BGTZ -> Branch
    - J -> Jmp; JAL -> Jal
    - ADDI, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU -> RIExec
    - LUI -> Lui
    - any other opcode -> Fetch (treated as a NOP)
- MemAddr: SrcaRs, SrcbImm, ADD. Goes to MemRd if LW, MemWr if SW.
- MemRd: mem_req=1, AddrALUout. Goes to MemWrbck on mem_rdy; otherwise holds.
- MemWrbck: reg_we, WrRt, MemData. Goes to Fetch.
- MemWr: mem_req=1, mem_we=1, AddrALUout. Goes to Fetch on mem_rdy. mem_we stays high while waiting.
- RRExec: SrcaRs, SrcbRt, ALUop_RR. Goes to RRWrbck.
- RRWrbck: reg_we, WrRd, ALUout. Goes to Fetch.
- Branch:
  - Operands: SrcaRs, ALUop_SUB. srcb = SrcbRt for BEQ/BNE, Zero for all others.
  - Taken condition:
    - BEQ: zero
    - BNE: !zero
    - BGEZ (rt=1): !sign
    - BLTZ (rt=0): sign
    - BLEZ: zero|sign
    - BGTZ: !zero&!sign
  - pc_we = taken, nxt PCBranch. Goes to Fetch.
  - The PC loads at the same edge that ALUout is overwritten.
- Jmp: pc_we, PCJmp. Goes to Fetch.
- RIExec:
  - Operands: SrcaRs, SrcbImm.
  - alu_op by opcode: ADDI=ADD, ADDIU=ADDU, ANDI=AND, ORI=OR, XORI=XOR, SLTI=SLT, SLTIU=SLTU.
  - Goes to RIWrbck.
- RIWrbck: reg_we, WrRt, ALUout. Goes to Fetch.
- Lui: reg_we, WrRt, LuiResult. Goes to Fetch.
- Jal: reg_we, WrRa, PCPlus4_j; pc_we, PCJmp. Goes to Fetch.
- Jalr: reg_we, WrRd, PCPlus4_j; pc_we, PCRs. Goes to Fetch.
- Jr: pc_we, PCRs. Goes to Fetch.
- Latency in cycles, with mem_rdy always high:
  - R-type and I-type ALU instructions: 4
  - LW: 5
  - SW: 4
  - branches and jumps: 3
  - LUI, JAL, JALR, JR: 3
- An unused state encoding is treated as Fetch (safe recovery).

Optional Feature:
MC_ILLEGAL_TRAP_EN.
- Defined:
  - An unrecognised opcode or an unknown RR funct in Decode goes to Halt (new state_type member).
  - Halt holds all enables at 0 until reset.
  - illegal_instr is set on entry to Halt and cleared only by rst_n.
  - Recognised RR functs: the set accepted by the ALU's RR decode, plus JR and JALR.
- Undefined: these cases behave as a NOP (straight to Fetch), and illegal_instr is tied to 0.

Decomposition:
- Shared packages:
  - MultcycCtrl: state_type (plus Halt) and all select enums.
  - ALUops: ALUop_t.
  - Opcodes: opcode and funct constants.
- No new constants are defined locally.
- One sub-module: mc_alu_dec, a combinational mapping of opcode to ALUop_t (RIExec table) and of opcode/rt to the branch-condition select.

Test Plan:
1. Reset: drop rst_n mid-MemRd -> state_o=Fetch immediately and all enables 0. Release it with mem_rdy=1 -> ir_we=pc_we=1 in the first cycle.
2. LW (opcode 0x23) with mem_rdy low 2 cycles in Fetch and 3 in MemRd -> sequence Fetch×3, Decode, MemAddr, MemRd×4, MemWrbck (reg_we=1, WrRt, MemData), then Fetch.
3. BEQ with alu_zero=1 -> Branch has pc_we=1, PCBranch. With alu_zero=0 -> pc_we=0. BGELTZ rt=0, alu_sign=1 -> taken; rt=1 -> not taken.
4. ADDIU (0x09) and SLTIU (0x0B) -> RIExec alu_op ALUop_ADDU and ALUop_SLTU respectively, then RIWrbck reg_we=1 WrRt.
5. RR with funct 0x09 (JALR) -> Jalr: reg_we=1, WrRd, PCPlus4_j, pc_we=1, PCRs. funct 0x08 (JR) -> reg_we=0.
6. Opcode 0x3F -> Decode goes to Fetch. With MC_ILLEGAL_TRAP_EN -> Halt, illegal_instr=1, held across 10 cycles with mem_rdy=1 until rst_n.
